// File: rtl/output_trace_capture_if.sv
// Event drain handshake: the capture block is the master presenting the FIFO head,
// the debug readout is the slave returning ready.
interface output_trace_capture_if #(
    parameter int DATA_W = 8,
    parameter int TS_W   = 16
);
    logic              ev_valid;
    logic              ev_ready;
    logic [DATA_W-1:0] ev_data;
    logic [TS_W-1:0]   ev_ts;

    modport master (output ev_valid, output ev_data, output ev_ts, input ev_ready);
    modport slave  (input ev_valid, input ev_data, input ev_ts, output ev_ready);
endinterface

// File: rtl/output_trace_capture.sv
// Output-bus trace monitor: records timestamped value changes into a FWFT FIFO
// and folds every armed sample into a CRC-8 (poly 0x07) signature.
module output_trace_capture #(
    parameter int DATA_W = 8,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_arm,
    input  logic [DATA_W-1:0]        i_mon_in,
    output_trace_capture_if.master   ev_if,
    output logic [$clog2(DEPTH):0]   o_ev_count,
    output logic                     o_overflow,
    output logic [7:0]               o_signature,
    output logic                     o_busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, CAPTURE} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [TS_W-1:0]   r_mem_ts   [DEPTH];
    logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
    logic [AW:0]       r_count;
    logic [TS_W-1:0]   r_ts;
    logic [DATA_W-1:0] r_last;
    logic              r_overflow;
    logic [7:0]        r_sig;

    logic       w_empty, w_full, w_pop, w_push_req, w_push, w_drop;
    logic [7:0] w_crc_next;

    function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [DATA_W-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (AW+1)'(DEPTH));
    // PRIME flushes the FIFO, so a pop requested on that edge is moot
    assign w_pop      = !w_empty && ev_if.ev_ready && (r_state != PRIME);
    assign w_push_req = (r_state == CAPTURE) && i_arm && (i_mon_in != r_last);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_crc_next = f_crc8((r_state == PRIME) ? 8'h00 : r_sig, i_mon_in);

    always_ff @(posedge i_clk) begin
        if (r_state == PRIME) begin
            r_mem_data[0] <= i_mon_in;
            r_mem_ts[0]   <= '0;
        end else if (w_push) begin
            r_mem_data[r_wr_ptr] <= i_mon_in;
            r_mem_ts[r_wr_ptr]   <= r_ts;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ts       <= '0;
            r_last     <= '0;
            r_overflow <= 1'b0;
            r_sig      <= 8'h00;
        end else begin
            case (r_state)
                IDLE: if (i_arm) r_state <= PRIME;
                PRIME: begin
                    r_ts       <= TS_W'(1);
                    r_last     <= i_mon_in;
                    r_overflow <= 1'b0;
                    r_sig      <= w_crc_next;
                    r_state    <= i_arm ? CAPTURE : IDLE;
                end
                CAPTURE: begin
                    if (!i_arm) begin
                        r_state <= IDLE;
                    end else begin
                        r_sig <= w_crc_next;
                        if (r_ts != '1) r_ts <= r_ts + TS_W'(1);
                        if (i_mon_in != r_last) r_last <= i_mon_in;
                        if (w_drop) r_overflow <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (r_state == PRIME) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= AW'(1);
                r_count  <= (AW+1)'(1);
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
        end
    end

    assign ev_if.ev_valid = !w_empty;
    assign ev_if.ev_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign ev_if.ev_ts    = w_empty ? '0 : r_mem_ts[r_rd_ptr];
    assign o_ev_count     = r_count;
    assign o_overflow     = r_overflow;
    assign o_signature    = r_sig;
    assign o_busy         = (r_state != IDLE);
endmodule

// File: tb/tb_output_trace_capture.sv
// Bench for output_trace_capture: directed scenarios plus randomized traffic,
// all compared against a transaction-level model of the trace FIFO and CRC.
module tb_output_trace_capture;
    localparam int DATA_W = 8;
    localparam int TS_W   = 16;
    localparam int DEPTH  = 8;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_arm = 1'b0;
    logic [DATA_W-1:0] i_mon_in = '0;
    logic [3:0]        o_ev_count;
    logic              o_overflow;
    logic [7:0]        o_signature;
    logic              o_busy;

    output_trace_capture_if #(.DATA_W(DATA_W), .TS_W(TS_W)) ev_if ();

    output_trace_capture #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_arm(i_arm), .i_mon_in(i_mon_in),
        .ev_if(ev_if), .o_ev_count(o_ev_count), .o_overflow(o_overflow),
        .o_signature(o_signature), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: phase 0=idle, 1=about to prime, 2=capturing
    int m_phase = 0;
    int m_qd[$];
    int m_qt[$];
    int m_ts = 0, m_last = 0, m_ovf = 0, m_sig = 0;

    // CRC as remainder of (crc^data)*x^8 mod x^8+x^2+x+1
    function automatic int crc_ref(input int crc, input int d);
        int v;
        v = ((crc ^ d) & 'hFF) << 8;
        for (int b = 15; b >= 8; b--)
            if (v[b]) v = v ^ ('h107 << (b - 8));
        return v & 'hFF;
    endfunction

    task automatic model_edge(input bit rst, input bit arm, input int mon, input bit rdy);
        bit popped;
        if (rst) begin
            m_phase = 0; m_qd = {}; m_qt = {};
            m_ts = 0; m_last = 0; m_ovf = 0; m_sig = 0;
            return;
        end
        if (m_phase == 1) begin
            m_qd = {mon}; m_qt = {0};
            m_ovf = 0; m_ts = 1; m_last = mon; m_sig = crc_ref(0, mon);
            m_phase = arm ? 2 : 0;
            return;
        end
        popped = 0;
        if (rdy && m_qd.size() > 0) begin
            void'(m_qd.pop_front()); void'(m_qt.pop_front());
            popped = 1;
        end
        if (m_phase == 0) begin
            if (arm) m_phase = 1;
        end else if (!arm) begin
            m_phase = 0;
        end else begin
            m_sig = crc_ref(m_sig, mon);
            if (mon != m_last) begin
                if (m_qd.size() < DEPTH) begin
                    m_qd.push_back(mon); m_qt.push_back(m_ts);
                end else m_ovf = 1;
                m_last = mon;
            end
            if (m_ts < 'hFFFF) m_ts++;
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".valid"}, int'(ev_if.ev_valid), int'(m_qd.size() > 0));
        chk({tag, ".count"}, int'(o_ev_count), m_qd.size());
        chk({tag, ".ovf"},   int'(o_overflow), m_ovf);
        chk({tag, ".sig"},   int'(o_signature), m_sig);
        chk({tag, ".busy"},  int'(o_busy), int'(m_phase != 0));
        if (m_qd.size() > 0) begin
            chk({tag, ".data"}, int'(ev_if.ev_data), m_qd[0]);
            chk({tag, ".ts"},   int'(ev_if.ev_ts), m_qt[0]);
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit arm, input int mon, input bit rdy);
        i_rst = rst; i_arm = arm; i_mon_in = DATA_W'(mon); ev_if.ev_ready = rdy;
        model_edge(rst, arm, mon, rdy);
        @(posedge i_clk);
        #1;
        compare(tag);
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        #2;

        // Reset with arbitrary inputs
        repeat (2) step("rst", 1, 1'($urandom), int'($urandom_range(255)), 1'($urandom));
        chk("rst.data0", int'(ev_if.ev_data), 0);
        chk("rst.ts0",   int'(ev_if.ev_ts), 0);
        step("rst_rel", 0, 0, 'h3C, 0);
        chk("rst_rel.sig0", int'(o_signature), 0);

        // Basic trace
        step("bt_arm", 0, 1, 'h01, 0);
        step("bt_prime", 0, 1, 'h01, 0);
        repeat (3) step("bt_hold", 0, 1, 'h01, 0);
        step("bt_chg", 0, 1, 'h02, 0);
        chk("bt.count", int'(o_ev_count), 2);
        step("bt_disarm", 0, 0, 'h02, 0);
        chk("bt.head0_d", int'(ev_if.ev_data), 'h01);
        chk("bt.head0_t", int'(ev_if.ev_ts), 0);
        step("bt_pop0", 0, 0, 'h02, 1);
        chk("bt.head1_d", int'(ev_if.ev_data), 'h02);
        chk("bt.head1_t", int'(ev_if.ev_ts), 4);
        step("bt_pop1", 0, 0, 'h02, 1);
        chk("bt.empty", int'(ev_if.ev_valid), 0);
        chk("bt.ovf", int'(o_overflow), 0);

        // Signature
        step("sg_arm", 0, 1, 'h00, 0);
        step("sg_prime", 0, 1, 'h01, 0);
        chk("sg.first", int'(o_signature), 'h07);
        step("sg_next", 0, 1, 'h02, 0);
        chk("sg.second", int'(o_signature), 'h1B);
        step("sg_disarm", 0, 0, 'h02, 0);

        // Overflow: 10 armed edges with a ramp
        step("ov_arm", 0, 1, 'h00, 0);
        for (int i = 1; i <= 10; i++) step("ov_ramp", 0, 1, i, 0);
        chk("ov.count", int'(o_ev_count), 8);
        chk("ov.flag", int'(o_overflow), 1);
        step("ov_disarm", 0, 0, 'h0A, 0);
        for (int i = 0; i < 8; i++) begin
            chk("ov.drain_d", int'(ev_if.ev_data), i + 1);
            chk("ov.drain_t", int'(ev_if.ev_ts), i);
            step("ov_pop", 0, 0, 'h0A, 1);
        end
        chk("ov.sticky", int'(o_overflow), 1);

        // Simultaneous push/pop while full
        step("pp_arm", 0, 1, 'h00, 0);
        for (int i = 1; i <= 8; i++) step("pp_fill", 0, 1, i, 0);
        chk("pp.full", int'(o_ev_count), 8);
        step("pp_both", 0, 1, 9, 1);
        chk("pp.count", int'(o_ev_count), 8);
        chk("pp.ovf", int'(o_overflow), 0);
        chk("pp.head", int'(ev_if.ev_data), 2);

        // Disarm mid-ramp: further changes ignored, FIFO retained
        step("da_off", 0, 0, 'h20, 0);
        for (int i = 0; i < 4; i++) step("da_idle", 0, 0, 'h21 + i, 0);
        chk("da.count", int'(o_ev_count), 8);
        step("da_pop", 0, 0, 'h30, 1);
        chk("da.drain", int'(o_ev_count), 7);

        // Re-arm flushes
        step("ra_arm", 0, 1, 'h00, 0);
        step("ra_prime", 0, 1, 'h55, 0);
        chk("ra.count", int'(o_ev_count), 1);
        chk("ra.ts", int'(ev_if.ev_ts), 0);
        chk("ra.data", int'(ev_if.ev_data), 'h55);
        chk("ra.ovf", int'(o_overflow), 0);

        // Reset while full and overflowed
        for (int i = 1; i <= 9; i++) step("rf_fill", 0, 1, 'h55 + i, 0);
        chk("rf.ovf_pre", int'(o_overflow), 1);
        step("rf_rst", 1, 1, 'hAA, 0);
        chk("rf.count", int'(o_ev_count), 0);
        chk("rf.sig", int'(o_signature), 0);
        chk("rf.busy", int'(o_busy), 0);
        chk("rf.data", int'(ev_if.ev_data), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step("rnd", ($urandom_range(199) == 0), ($urandom_range(15) != 0),
                 int'($urandom_range(3)) * 'h11, 1'($urandom_range(2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
